// File: rtl/aes_key_ctrl.sv
// Key-expansion sequencer and round-key store wrapped around the AES KeySchedule core.
// Accepts a cipher key, pulses reset/start on the core, captures its 11 round keys and serves them by index.
module aes_key_ctrl #(
    parameter int START_LEN = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key_in,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic          lock,
    output logic [127:0]  ks_key,
    output logic          ks_rst,
    output logic          ks_start,
    input  logic          ks_finish,
    input  logic [1279:0] ks_roundkeys,
    input  logic [3:0]    rk_idx,
    output logic [127:0]  rk_out,
    output logic          keys_valid,
    output logic          timeout_err
);

    localparam int SCW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [SCW-1:0] START_LOAD = SCW'(START_LEN - 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT - 1);
    localparam logic [3:0]     LAST_IDX   = 4'd10;

    typedef enum logic [1:0] {IDLE, KRST, KSTART, KWAIT} state_t;

    state_t         state, state_nxt;
    logic [SCW-1:0] start_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           finish_q;
    logic           finish_rise;
    logic           accept;
    logic           capture;
    logic           expire;
    logic [127:0]   slots [0:10];

    // Only a 0->1 transition seen while waiting counts; a level left high from before is ignored.
    assign finish_rise = ks_finish && !finish_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        key_ready = 1'b0;
        ks_rst    = 1'b0;
        ks_start  = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                key_ready = !lock;
                if (key_valid && !lock) begin
                    accept    = 1'b1;
                    state_nxt = KRST;
                end
            end
            KRST: begin
                ks_rst    = 1'b1;
                state_nxt = KSTART;
            end
            KSTART: begin
                ks_start = 1'b1;
                if (start_cnt == '0) state_nxt = KWAIT;
            end
            KWAIT: begin
                // A finish edge on the final allowed cycle still wins over the timeout.
                if (finish_rise) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            finish_q  <= 1'b0;
            start_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            finish_q <= ks_finish;
            if (state == KRST)                         start_cnt <= START_LOAD;
            else if (state == KSTART && start_cnt != '0) start_cnt <= start_cnt - 1'b1;
            if (state == KWAIT) wait_cnt <= wait_cnt + 1'b1;
            else                wait_cnt <= '0;
        end
    end

    // NOTE: the slot array is reset explicitly, so a reset mid-expansion can never expose a stale key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_key      <= '0;
            keys_valid  <= 1'b0;
            timeout_err <= 1'b0;
            for (int r = 0; r <= 10; r++) slots[r] <= '0;
        end else begin
            if (accept) begin
                ks_key      <= key_in;
                slots[0]    <= key_in;
                keys_valid  <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (capture) begin
                for (int r = 1; r <= 10; r++)
                    slots[r] <= ks_roundkeys[1279-128*(r-1) -: 128];
                keys_valid <= 1'b1;
            end
            if (expire) timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                rk_out <= '0;
        else if (keys_valid && rk_idx <= LAST_IDX) rk_out <= slots[rk_idx];
        else                                     rk_out <= '0;
    end

endmodule

// File: tb/tb_aes_key_ctrl.sv
// Directed bench for aes_key_ctrl: KeySchedule is stubbed by driving ks_finish/ks_roundkeys
// with the FIPS-197 expansion of the reference key.
module tb_aes_key_ctrl;

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] R4  = 128'hef44a541a8525b7fb671253bdb0bad00;
    localparam logic [127:0] R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] R6  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    localparam logic [127:0] R7  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    localparam logic [127:0] R8  = 128'head27321b58dbad2312bf5607f8d292f;
    localparam logic [127:0] R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [1279:0] RK_A = {R1, R2, R3, R4, R5, R6, R7, R8, R9, R10};
    localparam logic [127:0] K1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] K3 = 128'h1111111122222222333333334444444f;
    localparam logic [127:0] K4 = 128'hcafef00ddeadbeef0123456789abcdef;
    localparam logic [127:0] K5 = 128'h5a5a5a5aa5a5a5a5f0f0f0f00f0f0f0f;
    localparam logic [127:0] K6 = 128'h13579bdf02468ace13579bdf02468ace;
    localparam logic [127:0] K7 = 128'h7777777788888888999999996666666a;
    localparam logic [127:0] K8 = 128'hfedcba9876543210fedcba9876543210;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  key_in;
    logic          key_valid;
    logic          key_ready;
    logic          lock;
    logic [127:0]  ks_key;
    logic          ks_rst;
    logic          ks_start;
    logic          ks_finish;
    logic [1279:0] ks_roundkeys;
    logic [3:0]    rk_idx;
    logic [127:0]  rk_out;
    logic          keys_valid;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_key_ctrl #(.START_LEN(2), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .lock         (lock),
        .ks_key       (ks_key),
        .ks_rst       (ks_rst),
        .ks_start     (ks_start),
        .ks_finish    (ks_finish),
        .ks_roundkeys (ks_roundkeys),
        .rk_idx       (rk_idx),
        .rk_out       (rk_out),
        .keys_valid   (keys_valid),
        .timeout_err  (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the accept edge: walks KRST/KSTART, then pulses finish in the first KWAIT cycle.
    task automatic finish_run();
        repeat (3) tick();
        ks_finish = 1'b1;
        tick();
        ks_finish = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; key_in = '0; key_valid = 1'b0; lock = 1'b0;
        ks_finish = 1'b0; ks_roundkeys = RK_A; rk_idx = 4'd0;
        #12;
        checks++; if (ks_key !== 128'h0) begin errors++; $display("FAIL reset_ks_key: got %h want 0", ks_key); end
        checks++; if ({ks_rst, ks_start, keys_valid, timeout_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {ks_rst, ks_start, keys_valid, timeout_err}); end
        checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
        rst = 1'b1;
        tick();
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
    endtask

    task automatic test_basic();
        key_in = K0; key_valid = 1'b1; rk_idx = 4'd1;
        #1;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", key_ready); end
        tick();
        key_valid = 1'b0;
        checks++; if ({ks_rst, ks_start} !== 2'b10) begin errors++; $display("FAIL basic_krst: got %b want 10", {ks_rst, ks_start}); end
        checks++; if (ks_key !== K0) begin errors++; $display("FAIL basic_ks_key: got %h want %h", ks_key, K0); end
        tick();
        checks++; if ({ks_rst, ks_start} !== 2'b01) begin errors++; $display("FAIL basic_start1: got %b want 01", {ks_rst, ks_start}); end
        tick();
        checks++; if ({ks_rst, ks_start} !== 2'b01) begin errors++; $display("FAIL basic_start2: got %b want 01", {ks_rst, ks_start}); end
        tick();
        checks++; if ({ks_start, key_ready, keys_valid} !== 3'b000) begin
            errors++; $display("FAIL basic_kwait: got %b want 000", {ks_start, key_ready, keys_valid}); end
        ks_finish = 1'b1;
        tick();
        checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", keys_valid); end
        checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL basic_rk_lat: got %h want 0", rk_out); end
        ks_finish = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_again: got %b want 1", key_ready); end
        tick();
        checks++; if (rk_out !== R1) begin errors++; $display("FAIL basic_rk1: got %h want %h", rk_out, R1); end
        rk_idx = 4'd0;
        tick();
        checks++; if (rk_out !== K0) begin errors++; $display("FAIL basic_rk0: got %h want %h", rk_out, K0); end
        rk_idx = 4'd10;
        #1;
        checks++; if (rk_out !== K0) begin errors++; $display("FAIL basic_rk_hold: got %h want %h", rk_out, K0); end
        tick();
        checks++; if (rk_out !== R10) begin errors++; $display("FAIL basic_rk10: got %h want %h", rk_out, R10); end
        rk_idx = 4'd12;
        tick();
        checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL basic_rk12: got %h want 0", rk_out); end
        rk_idx = 4'd5;
        tick();
        checks++; if (rk_out !== R5) begin errors++; $display("FAIL basic_rk5: got %h want %h", rk_out, R5); end
    endtask

    task automatic test_lock();
        logic bad;
        bad = 1'b0;
        lock = 1'b1; key_valid = 1'b1; key_in = K1; rk_idx = 4'd0;
        repeat (20) begin
            #1;
            if (key_ready !== 1'b0 || ks_rst !== 1'b0 || keys_valid !== 1'b1) bad = 1'b1;
            tick();
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL lock_blocked: got %b want 0", bad); end
        checks++; if (rk_out !== K0) begin errors++; $display("FAIL lock_slot0: got %h want %h", rk_out, K0); end
        lock = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL lock_release_ready: got %b want 1", key_ready); end
        tick();
        key_valid = 1'b0;
        checks++; if ({keys_valid, ks_rst} !== 2'b01) begin errors++; $display("FAIL lock_accept: got %b want 01", {keys_valid, ks_rst}); end
        checks++; if (ks_key !== K1) begin errors++; $display("FAIL lock_ks_key: got %h want %h", ks_key, K1); end
        finish_run();
    endtask

    task automatic test_timeout();
        key_in = K2; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (3) tick();
        repeat (7) tick();
        checks++; if ({timeout_err, key_ready} !== 2'b00) begin errors++; $display("FAIL to_early: got %b want 00", {timeout_err, key_ready}); end
        tick();
        checks++; if ({timeout_err, keys_valid, key_ready} !== 3'b101) begin
            errors++; $display("FAIL to_fire: got %b want 101", {timeout_err, keys_valid, key_ready}); end
        key_in = K3; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
        checks++; if (ks_key !== K3) begin errors++; $display("FAIL to_next_key: got %h want %h", ks_key, K3); end
        finish_run();
        checks++; if (keys_valid !== 1'b1) begin errors++; $display("FAIL to_recover: got %b want 1", keys_valid); end
    endtask

    task automatic test_stale_and_tie();
        logic [127:0] exp_r1;
        ks_finish = 1'b1;
        key_in = K4; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (5) tick();
        checks++; if ({keys_valid, key_ready} !== 2'b00) begin errors++; $display("FAIL stale_nocap: got %b want 00", {keys_valid, key_ready}); end
        ks_finish = 1'b0;
        tick();
        ks_finish = 1'b1;
        tick();
        ks_finish = 1'b0;
        checks++; if ({keys_valid, timeout_err} !== 2'b10) begin errors++; $display("FAIL stale_cap: got %b want 10", {keys_valid, timeout_err}); end
        rk_idx = 4'd0;
        tick();
        checks++; if (rk_out !== K4) begin errors++; $display("FAIL stale_slot0: got %h want %h", rk_out, K4); end

        ks_roundkeys = ~RK_A;
        exp_r1 = ~R1;
        key_in = K5; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (10) tick();
        ks_finish = 1'b1;
        tick();
        ks_finish = 1'b0;
        checks++; if ({keys_valid, timeout_err, key_ready} !== 3'b101) begin
            errors++; $display("FAIL tie_cap: got %b want 101", {keys_valid, timeout_err, key_ready}); end
        rk_idx = 4'd1;
        tick();
        checks++; if (rk_out !== exp_r1) begin errors++; $display("FAIL tie_slot1: got %h want %h", rk_out, exp_r1); end
        ks_roundkeys = RK_A;
    endtask

    task automatic test_async_reset();
        key_in = K6; key_valid = 1'b1; rk_idx = 4'd0;
        tick();
        key_valid = 1'b0;
        repeat (3) tick();
        checks++; if (ks_key !== K6) begin errors++; $display("FAIL ar_pre_key: got %h want %h", ks_key, K6); end
        #1 rst = 1'b0;
        #1;
        checks++; if (ks_key !== 128'h0) begin errors++; $display("FAIL ar_ks_key: got %h want 0", ks_key); end
        checks++; if ({ks_rst, ks_start, keys_valid, timeout_err} !== 4'b0000 || rk_out !== 128'h0) begin
            errors++; $display("FAIL ar_outputs: got %b/%h want 0000/0", {ks_rst, ks_start, keys_valid, timeout_err}, rk_out); end
        #2 rst = 1'b1;
        tick();
        checks++; if ({key_ready, ks_rst, ks_start} !== 3'b100) begin
            errors++; $display("FAIL ar_idle: got %b want 100", {key_ready, ks_rst, ks_start}); end
        ks_finish = 1'b1;
        tick();
        ks_finish = 1'b0;
        tick();
        checks++; if ({keys_valid, rk_out != 128'h0} !== 2'b00) begin
            errors++; $display("FAIL ar_no_capture: got %b want 00", {keys_valid, rk_out != 128'h0}); end
    endtask

    task automatic test_back_to_back();
        key_in = K7; key_valid = 1'b1;
        tick();
        key_in = K8;
        repeat (3) tick();
        ks_finish = 1'b1;
        tick();
        ks_finish = 1'b0;
        checks++; if ({keys_valid, key_ready} !== 2'b11) begin errors++; $display("FAIL b2b_first: got %b want 11", {keys_valid, key_ready}); end
        checks++; if (ks_key !== K7) begin errors++; $display("FAIL b2b_key1: got %h want %h", ks_key, K7); end
        tick();
        key_valid = 1'b0;
        checks++; if ({ks_rst, keys_valid} !== 2'b10) begin errors++; $display("FAIL b2b_accept2: got %b want 10", {ks_rst, keys_valid}); end
        checks++; if (ks_key !== K8) begin errors++; $display("FAIL b2b_key2: got %h want %h", ks_key, K8); end
        finish_run();
        rk_idx = 4'd0;
        tick();
        checks++; if (rk_out !== K8) begin errors++; $display("FAIL b2b_slot0: got %h want %h", rk_out, K8); end
        rk_idx = 4'd9;
        tick();
        checks++; if (rk_out !== R9) begin errors++; $display("FAIL b2b_slot9: got %h want %h", rk_out, R9); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lock();
        test_timeout();
        test_stale_and_tie();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
